// File: rtl/wb_sram_slave_if.sv
// if_wb: single-beat Wishbone bus between the cache master and the SRAM slave.
interface if_wb;
  logic [31:0] adr;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        stall;
  modport master (output adr, dat_i, sel, we, cyc, stb, input dat_o, ack, stall);
  modport slave  (input adr, dat_i, sel, we, cyc, stb, output dat_o, ack, stall);
endinterface

// File: rtl/wb_sram_slave.sv
// wb_sram_slave: serves 32-bit Wishbone words as two halfword accesses to an async 16-bit SRAM.
// Optional SRAM_PIPE_EN accepts the next request during the ack cycle.
module wb_sram_slave #(
  parameter int AWIDTH = 20,
  parameter int WAIT   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  if_wb.slave               inbus,
  output logic [AWIDTH-1:0] sram_addr,
  input  logic [15:0]       sram_dq_i,
  output logic [15:0]       sram_dq_o,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);
`ifdef SRAM_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif
  typedef enum logic [2:0] {S_IDLE, S_LO, S_LO_END, S_HI, S_HI_END, S_ACK} state_t;
  state_t            r_state, w_nxt, w_first;
  logic [3:0]        r_cnt;
  logic [AWIDTH-2:0] r_adr, w_adr;
  logic [31:0]       r_dat, w_dat, r_dat_o;
  logic [3:0]        r_sel, w_sel;
  logic              r_we, w_we, r_stall, r_abort;
  logic              w_acc, w_lo, w_hi, w_ok, w_done, w_act, w_end, w_half;
  assign inbus.ack   = r_state == S_ACK && inbus.cyc;
  assign inbus.stall = r_stall;
  assign inbus.dat_o = r_dat_o;
  // request fields come straight from the bus on the accept cycle, else from the latches
  always_comb begin
    w_acc   = inbus.cyc & inbus.stb & (r_state == S_IDLE || (PIPE && r_state == S_ACK));
    w_we    = w_acc ? inbus.we : r_we;
    w_sel   = w_acc ? inbus.sel : r_sel;
    w_adr   = w_acc ? inbus.adr[AWIDTH:2] : r_adr;
    w_dat   = w_acc ? inbus.dat_i : r_dat;
    w_lo    = ~w_we | (|w_sel[1:0]);
    w_hi    = ~w_we | (|w_sel[3:2]);
    w_first = w_lo ? S_LO : w_hi ? S_HI : S_ACK;
    w_ok    = inbus.cyc & ~r_abort;
    w_done  = r_cnt == 4'd0;
    w_nxt   = (r_state == S_IDLE || r_state == S_ACK) ? (w_acc ? w_first : S_IDLE) :
              r_state == S_LO ? (w_done ? S_LO_END : S_LO) :
              r_state == S_HI ? (w_done ? S_HI_END : S_HI) :
              !w_ok ? S_IDLE :
              r_state == S_LO_END ? (w_hi ? S_HI : S_ACK) : S_ACK;
    w_act   = w_nxt == S_LO || w_nxt == S_HI;
    w_end   = w_nxt == S_LO_END || w_nxt == S_HI_END;
    w_half  = w_nxt == S_HI || w_nxt == S_HI_END;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'(WAIT);
      r_adr      <= '0;
      r_dat      <= '0;
      r_sel      <= '0;
      r_we       <= 1'b0;
      r_stall    <= 1'b0;
      r_abort    <= 1'b0;
      r_dat_o    <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= (r_state == S_LO || r_state == S_HI) ? r_cnt - 4'd1 : 4'(WAIT);
      if (w_acc) begin
        r_adr   <= w_adr;
        r_dat   <= w_dat;
        r_sel   <= w_sel;
        r_we    <= w_we;
        r_abort <= 1'b0;
      end else if (!inbus.cyc && r_state != S_IDLE) begin
        r_abort <= 1'b1;
      end
      r_stall <= !(w_nxt == S_IDLE || (PIPE && w_nxt == S_ACK));
      if (!r_we && w_done && r_state == S_LO) r_dat_o[15:0] <= sram_dq_i;
      if (!r_we && w_done && r_state == S_HI) r_dat_o[31:16] <= sram_dq_i;
      // END cycles keep address and write data stable for SRAM hold time
      sram_addr  <= (w_act | w_end) ? {w_adr, w_half} : sram_addr;
      sram_dq_o  <= ((w_act | w_end) && w_we) ? (w_half ? w_dat[31:16] : w_dat[15:0]) : sram_dq_o;
      sram_dq_oe <= (w_act | w_end) & w_we;
      sram_ce_n  <= !(w_act | w_end);
      sram_oe_n  <= !(w_act & ~w_we);
      sram_we_n  <= !(w_act & w_we);
      sram_ub_n  <= !(w_act | w_end) | (w_we & !(w_half ? w_sel[3] : w_sel[1]));
      sram_lb_n  <= !(w_act | w_end) | (w_we & !(w_half ? w_sel[2] : w_sel[0]));
    end
  end
endmodule
